// File: rtl/util_fifo_v2.sv
// Single-clock FIFO using all 2**ADDR_W slots, with level flags, sticky error flags and synchronous flush.
// The FWFT parameter selects a registered read port (1-cycle latency) or an asynchronous first-word-fall-through read port.
module util_fifo_v2 #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 3,
  parameter bit FWFT      = 1'b0,
  parameter int AF_THRESH = (1 << ADDR_W) - 2,
  parameter int AE_THRESH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] din,
  input  logic              rd_en,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow,
  input  logic              clr_err
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] AF_LVL = (ADDR_W+1)'(AF_THRESH);
  localparam logic [ADDR_W:0] AE_LVL = (ADDR_W+1)'(AE_THRESH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W:0]   wr_ptr;
  logic [ADDR_W:0]   rd_ptr;
  logic              wr_acc;
  logic              rd_acc;
  logic              ovf_evt;
  logic              unf_evt;

  // The extra pointer bit distinguishes full from empty when the low bits match.
  assign count        = wr_ptr - rd_ptr;
  assign empty        = (wr_ptr == rd_ptr);
  assign full         = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                        (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign almost_full  = (count >= AF_LVL);
  assign almost_empty = (count <= AE_LVL);

  assign wr_acc  = wr_en & ~full  & ~flush;
  assign rd_acc  = rd_en & ~empty & ~flush;
  assign ovf_evt = wr_en &  full  & ~flush;
  assign unf_evt = rd_en &  empty & ~flush;

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr[ADDR_W-1:0]] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // A new error event in the same cycle as clr_err keeps the flag set.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= ovf_evt | (overflow  & ~clr_err);
      underflow <= unf_evt | (underflow & ~clr_err);
    end
  end

  if (FWFT) begin : g_fwft
    assign dout       = mem[rd_ptr[ADDR_W-1:0]];
    assign dout_valid = ~empty;
  end else begin : g_std
    logic [DATA_W-1:0] dout_q;
    logic              dout_valid_q;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        dout_q       <= '0;
        dout_valid_q <= 1'b0;
      end else begin
        dout_valid_q <= rd_acc;
        if (rd_acc) dout_q <= mem[rd_ptr[ADDR_W-1:0]];
      end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
  end

endmodule

// File: tb/tb_util_fifo_v2.sv
// Directed bench for util_fifo_v2: a queue scoreboard for the standard-mode instance plus directed FWFT checks.
module tb_util_fifo_v2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0, wr_en = 1'b0, rd_en = 1'b0, clr_err = 1'b0;
  logic [31:0] din = '0;
  logic [31:0] dout;
  logic        dout_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [3:0]  count;

  logic        f_flush = 1'b0, f_wr_en = 1'b0, f_rd_en = 1'b0, f_clr_err = 1'b0;
  logic [31:0] f_din = '0;
  logic [31:0] f_dout;
  logic        f_dout_valid, f_full, f_empty, f_almost_full, f_almost_empty, f_overflow, f_underflow;
  logic [3:0]  f_count;

  int          checks = 0;
  int          errors = 0;
  int          mcnt = 0;
  logic        movf = 1'b0, munf = 1'b0;
  logic [31:0] q[$];

  always #5 clk = ~clk;

  util_fifo_v2 #(.DATA_W(32), .ADDR_W(3), .FWFT(1'b0)) u_std (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .dout(dout), .dout_valid(dout_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
  );

  util_fifo_v2 #(.DATA_W(32), .ADDR_W(3), .FWFT(1'b1)) u_fwft (
    .clk(clk), .rst_n(rst_n), .flush(f_flush), .wr_en(f_wr_en), .din(f_din), .rd_en(f_rd_en),
    .dout(f_dout), .dout_valid(f_dout_valid), .full(f_full), .empty(f_empty),
    .almost_full(f_almost_full), .almost_empty(f_almost_empty), .count(f_count),
    .overflow(f_overflow), .underflow(f_underflow), .clr_err(f_clr_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One cycle on the standard instance; the scoreboard predicts acceptance from its own occupancy.
  task automatic cyc(input logic wr, input logic [31:0] d, input logic rd,
                     input logic clr, input logic fl);
    logic        wacc, racc, ovf_ev, unf_ev;
    logic [31:0] e;
    e      = '0;
    wacc   = !fl && wr && (mcnt < 8);
    racc   = !fl && rd && (mcnt > 0);
    ovf_ev = !fl && wr && (mcnt == 8);
    unf_ev = !fl && rd && (mcnt == 0);
    if (racc) e = q.pop_front();
    if (wacc) q.push_back(d);
    if (fl) q.delete();
    mcnt = q.size();
    movf = ovf_ev | (movf & !clr);
    munf = unf_ev | (munf & !clr);
    wr_en = wr; din = d; rd_en = rd; clr_err = clr; flush = fl;
    tick();
    wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; flush = 1'b0;
    chk("count",        32'(count),        32'(mcnt));
    chk("full",         32'(full),         32'(mcnt == 8));
    chk("empty",        32'(empty),        32'(mcnt == 0));
    chk("almost_full",  32'(almost_full),  32'(mcnt >= 6));
    chk("almost_empty", 32'(almost_empty), 32'(mcnt <= 2));
    chk("overflow",     32'(overflow),     32'(movf));
    chk("underflow",    32'(underflow),    32'(munf));
    chk("dout_valid",   32'(dout_valid),   32'(racc));
    if (racc) chk("dout", dout, e);
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    tick();
    q.delete(); mcnt = 0; movf = 1'b0; munf = 1'b0;
    chk("rst_dout",         dout,                 32'h0);
    chk("rst_dout_valid",   32'(dout_valid),      32'h0);
    chk("rst_empty",        32'(empty),           32'h1);
    chk("rst_full",         32'(full),            32'h0);
    chk("rst_count",        32'(count),           32'h0);
    chk("rst_almost_empty", 32'(almost_empty),    32'h1);
    chk("rst_almost_full",  32'(almost_full),     32'h0);
    chk("rst_overflow",     32'(overflow),        32'h0);
    chk("rst_underflow",    32'(underflow),       32'h0);
    chk("rst_f_empty",      32'(f_empty),         32'h1);
    rst_n = 1'b1;
  endtask

  initial begin
    tick();
    do_reset();

    // Fill then confirm a write while full is dropped and flagged.
    for (int i = 0; i < 8; i++) cyc(1'b1, 32'h10 + 32'(i), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'hDEAD, 1'b0, 1'b0, 1'b0);

    // Drain in order, then read while empty.
    for (int i = 0; i < 8; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Clear errors; then clear together with a fresh underflow event.
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

    // Concurrent read/write at count 4 across pointer wrap.
    for (int i = 0; i < 4; i++) cyc(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cyc(1'b1, 32'h200 + 32'(i), 1'b1, 1'b0, 1'b0);

    // Simultaneous read/write while full: read taken, write rejected.
    for (int i = 0; i < 4; i++) cyc(1'b1, 32'h300 + 32'(i), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'hBEEF, 1'b1, 1'b0, 1'b0);
    chk("full_rw_count", 32'(count), 32'd7);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

    // Flush at count 5 with a concurrent write request.
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("pre_flush_count", 32'(count), 32'd5);
    cyc(1'b1, 32'h400, 1'b1, 1'b0, 1'b1);

    // Refill three words, reset mid-stream, then move new data.
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h500 + 32'(i), 1'b0, 1'b0, 1'b0);
    do_reset();
    cyc(1'b1, 32'h77, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // FWFT instance: written word appears without a read.
    f_wr_en = 1'b1; f_din = 32'hA5;
    tick();
    chk("fwft_empty_after_wr", 32'(f_empty),      32'h0);
    chk("fwft_dout_first",     f_dout,            32'hA5);
    chk("fwft_valid_first",    32'(f_dout_valid), 32'h1);
    f_din = 32'h5A;
    tick();
    f_wr_en = 1'b0;
    chk("fwft_dout_hold",      f_dout,            32'hA5);
    chk("fwft_count2",         32'(f_count),      32'd2);
    f_rd_en = 1'b1;
    tick();
    chk("fwft_dout_next",      f_dout,            32'h5A);
    chk("fwft_empty_mid",      32'(f_empty),      32'h0);
    tick();
    f_rd_en = 1'b0;
    chk("fwft_empty_end",      32'(f_empty),      32'h1);
    chk("fwft_valid_end",      32'(f_dout_valid), 32'h0);
    chk("fwft_underflow",      32'(f_underflow),  32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/util_fifo_v2.md
Name: util_fifo_v2

Overview:
- Parametrised synchronous single-clock FIFO; successor to the fixed-depth utility FIFO.
- Stores all 2**ADDR_W entries (no sacrificed slot) and reports occupancy and almost-full/almost-empty levels.
- Has sticky overflow/underflow error flags, a synchronous flush, and two read modes: registered standard, and first-word-fall-through (FWFT).
- Sits between AXI/DMA front-ends and the accelerator datapath for operand/result buffering.

Parameters:
- DATA_W, 32, data word width in bits (≥1).
- ADDR_W, 3, address width; DEPTH = 2**ADDR_W entries (ADDR_W 1..12).
- FWFT, 0, read mode. 0 = standard (registered dout, 1-cycle latency). 1 = first-word-fall-through.
- AF_THRESH, DEPTH-2, almost_full asserts when count ≥ AF_THRESH.
- AE_THRESH, 2, almost_empty asserts when count ≤ AE_THRESH.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- flush  in  1  synchronous clear of FIFO contents (pointers only).
- wr_en  in  1  write request.
- din  in  DATA_W  write data.
- rd_en  in  1  read/pop request.
- dout  out  DATA_W  read data.
- dout_valid  out  1  dout holds a newly popped word (FWFT=0); equals ~empty (FWFT=1).
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count ≥ AF_THRESH.
- almost_empty  out  1  count ≤ AE_THRESH.
- count  out  ADDR_W+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a write was attempted while full.
- underflow  out  1  sticky: a read was attempted while empty.
- clr_err  in  1  clears overflow/underflow.

Behaviour:
- Pointers:
  - wr_ptr and rd_ptr are ADDR_W+1 bits; RAM is indexed by the low ADDR_W bits.
  - count = wr_ptr − rd_ptr, modulo 2**(ADDR_W+1).
  - full when the MSBs differ and the low bits are equal; empty when the pointers are equal.
  - Wrap-around is natural binary rollover.
- Write acceptance:
  - wr_acc = wr_en & ~full.
  - On wr_acc: mem[wr_ptr] <= din, and wr_ptr increments.
  - wr_en while full: data is dropped, wr_ptr unchanged, overflow <= 1.
- Read acceptance:
  - rd_acc = rd_en & ~empty; on rd_acc, rd_ptr increments.
  - rd_en while empty: no pointer change, underflow <= 1.
- Simultaneous accepted read and write: both pointers advance and count is unchanged.
  - Full is evaluated before the pop, so a write while full is rejected even when a read is accepted the same cycle.
  - Empty is evaluated before the push, so a read while empty is rejected even when a write is accepted the same cycle.
- Flags and count are registered-state derived; each updates the cycle after the causing edge.
- FWFT=0 (standard mode):
  - On rd_acc, dout <= mem[rd_ptr] and dout_valid <= 1 in the next cycle; latency is 1 clk from the rd_en edge.
  - Without rd_acc, dout holds its previous value and dout_valid <= 0.
- FWFT=1 (first-word-fall-through mode):
  - dout = mem[rd_ptr low bits] (asynchronous read); valid whenever ~empty.
  - A word written at edge N appears on dout, with empty deasserted, after edge N.
  - rd_acc at edge M presents the next word after edge M.
  - dout is don't-care while empty.
- flush = 1:
  - wr_ptr <= 0, rd_ptr <= 0, dout_valid <= 0.
  - wr_en and rd_en are ignored that cycle and do not set the error flags.
  - dout and the RAM contents are unaffected.
  - flush has priority over wr/rd but not over reset.
- clr_err = 1 clears overflow and underflow. If an error event occurs in the same cycle, the flag is set (set wins).
- Reset (rst_n = 0):
  - wr_ptr = rd_ptr = 0, dout = 0, dout_valid = 0, overflow = underflow = 0.
  - Hence empty = 1, full = 0, count = 0, almost_empty = 1, almost_full = 0.
  - Reset during an ongoing stream discards all contents; the RAM itself is not cleared.
- The RAM is inferable as distributed RAM in FWFT=1, and as block or distributed RAM in FWFT=0.

Test Plan:
- Fill/drain, FWFT=0, DATA_W=32, ADDR_W=3:
  - Write 0x10..0x17 on 8 consecutive cycles → full = 1 and count = 8 after the 8th edge; almost_full rises when count reaches 6.
  - Then read 8 → dout 0x10..0x17, each 1 cycle after its rd_en, with dout_valid pulsed; empty = 1 at the end.
- Overflow/underflow:
  - With full, assert wr_en din = 0xDEAD → overflow = 1 and count stays 8.
  - Drain, then rd_en on empty → underflow = 1.
  - clr_err → both flags 0; clr_err together with a new error event → the flag stays 1.
- Concurrent read/write at count = 4:
  - Assert wr_en and rd_en together for 20 cycles with an incrementing din → count stays 4 throughout, and the output order matches the input order across pointer wrap.
  - Simultaneous read/write while full → read accepted, write rejected, count = 7, overflow = 1.
- FWFT=1:
  - Write 0xA5 into an empty FIFO → empty = 0 and dout = 0xA5 after the same edge, without any rd_en.
  - Then rd_en → the next word appears, or empty = 1 if none remains.
- Flush and reset mid-stream:
  - At count = 5, pulse flush with wr_en = 1 → count = 0, empty = 1, no write taken, no error flag set.
  - Refill 3 words, then rst_n = 0 for 1 cycle → all outputs at their reset values.
  - A subsequent write/read returns the new data.
